// File: rtl/hilo_div_ctrl.sv
// ============================================================================
// hilo_div_ctrl
// ----------------------------------------------------------------------------
// Issue and writeback controller sitting between the EX stage and the
// 32-stage pipelined divider. A DIV/DIVU seen in EX is captured into operand
// registers, handed to the divider with a single-cycle request, and the
// pipeline is held until the divider's completion pulse. The quotient is then
// committed to LO and the remainder to HI. The block also owns the
// architectural HI/LO registers, serves MTHI/MTLO writes while idle, and
// discards the result of a division that was flushed while in flight.
//
// No arithmetic happens here; signedness is forwarded to the divider.
//
// Ports
//   clk           in   core clock, shared with the divider
//   resetn        in   asynchronous active-low reset
//   ex_div_valid  in   EX holds a DIV/DIVU
//   ex_div_signed in   1 = DIV, 0 = DIVU
//   ex_src_a      in   [31:0] dividend (rs)
//   ex_src_b      in   [31:0] divisor (rt)
//   ex_hilo_use   in   EX holds MFHI/MFLO/MTHI/MTLO
//   ex_mthi       in   MTHI write request
//   ex_mtlo       in   MTLO write request
//   ex_wdata      in   [31:0] MTHI/MTLO write data
//   flush         in   exception/eret flush of EX and younger
//   stall         out  hold EX and upstream
//   div_req       out  one-cycle request to the divider
//   div_signed    out  signedness to the divider (0 when div_req=0)
//   div_x         out  [31:0] dividend to the divider (0 when div_req=0)
//   div_y         out  [31:0] divisor to the divider (0 when div_req=0)
//   div_s         in   [31:0] divider quotient
//   div_r         in   [31:0] divider remainder
//   div_complete  in   divider result valid, one-cycle pulse
//   hi            out  [31:0] HI register
//   lo            out  [31:0] LO register
//
// Build option
//   DIV_ZERO_SKIP_EN : when defined, a division by zero skips the divider
//                      entirely (no request, HI/LO unchanged, one stall
//                      cycle). When undefined, a zero divisor takes the
//                      normal path and HI/LO receive whatever the divider
//                      returns.
// ============================================================================
module hilo_div_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_div_valid,
    input  logic        ex_div_signed,
    input  logic [31:0] ex_src_a,
    input  logic [31:0] ex_src_b,
    input  logic        ex_hilo_use,
    input  logic        ex_mthi,
    input  logic        ex_mtlo,
    input  logic [31:0] ex_wdata,
    input  logic        flush,
    output logic        stall,
    output logic        div_req,
    output logic        div_signed,
    output logic [31:0] div_x,
    output logic [31:0] div_y,
    input  logic [31:0] div_s,
    input  logic [31:0] div_r,
    input  logic        div_complete,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e      state_q,   state_d;
    logic        discard_q, discard_d;
    logic [31:0] hi_q,      hi_d;
    logic [31:0] lo_q,      lo_d;
    logic [31:0] opa_q,     opa_d;
    logic [31:0] opb_q,     opb_d;
    logic        sgn_q,     sgn_d;

    logic        stall_s;
    logic        req_s;

    // State, discard flag, operand and HI/LO registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            discard_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            opa_q     <= 32'd0;
            opb_q     <= 32'd0;
            sgn_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            sgn_q     <= sgn_d;
        end
    end

    // Next-state, operand capture and HI/LO update logic.
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        sgn_d     = sgn_q;

        case (state_q)
            ST_IDLE: begin
                if (ex_div_valid && !flush) begin
                    opa_d = ex_src_a;
                    opb_d = ex_src_b;
                    sgn_d = ex_div_signed;
`ifdef DIV_ZERO_SKIP_EN
                    // Zero divisor: retire immediately without touching HI/LO.
                    if (ex_src_b == 32'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
`else
                    state_d = ST_ISSUE;
`endif
                end else begin
                    if (ex_mthi && !flush) begin
                        hi_d = ex_wdata;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (ex_mtlo && !flush) begin
                        lo_d = ex_wdata;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end

            ST_ISSUE: begin
                // A flush here suppresses the request, so the divider never
                // starts and there is nothing to wait for.
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (div_complete) begin
                    discard_d = 1'b0;
                    // A flush coinciding with completion also kills the result.
                    if (discard_q || flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        lo_d    = div_s;
                        hi_d    = div_r;
                        state_d = ST_DONE;
                    end
                end else if (flush) begin
                    // The divider cannot be cancelled; remember to drop its
                    // eventual result instead.
                    discard_d = 1'b1;
                end else begin
                    discard_d = discard_q;
                end
            end

            ST_DONE: begin
                // The stalled DIV retires this cycle; EX inputs are ignored.
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                discard_d = 1'b0;
            end
        endcase
    end

    // Stall and divider request decode.
    always_comb begin
        stall_s = 1'b0;
        req_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stall_s = ex_div_valid & ~flush;
            end

            ST_ISSUE, ST_WAIT: begin
                // While a live division is pending, EX is held. Once it is
                // being discarded, only instructions that need the divider
                // or HI/LO must wait for it to drain.
                if (discard_q || flush) begin
                    stall_s = ex_div_valid | ex_hilo_use;
                end else begin
                    stall_s = 1'b1;
                end
                if ((state_q == ST_ISSUE) && !flush) begin
                    req_s = 1'b1;
                end else begin
                    req_s = 1'b0;
                end
            end

            ST_DONE: begin
                stall_s = 1'b0;
            end

            default: begin
                stall_s = 1'b0;
                req_s   = 1'b0;
            end
        endcase
    end

    assign stall      = stall_s;
    assign div_req    = req_s;
    // Operands are only presented alongside the request, zero otherwise.
    assign div_signed = req_s ? sgn_q : 1'b0;
    assign div_x      = req_s ? opa_q : 32'd0;
    assign div_y      = req_s ? opb_q : 32'd0;
    assign hi         = hi_q;
    assign lo         = lo_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// ============================================================================
// tb_hilo_div_ctrl
// Scoreboard bench for hilo_div_ctrl. Stimulus pushes the expected stall value
// for every driven cycle, the expected divider requests (with the cycle they
// must appear in) and the expected HI/LO updates (with their cycle). A
// separate monitor pops and compares at each falling edge. A behavioural
// divider answers div_req with div_complete in the 33rd cycle after the
// request cycle.
// ============================================================================
module tb_hilo_div_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ex_div_valid = 1'b0;
    logic        ex_div_signed = 1'b0;
    logic [31:0] ex_src_a = 32'd0;
    logic [31:0] ex_src_b = 32'd0;
    logic        ex_hilo_use = 1'b0;
    logic        ex_mthi = 1'b0;
    logic        ex_mtlo = 1'b0;
    logic [31:0] ex_wdata = 32'd0;
    logic        flush = 1'b0;
    logic        stall;
    logic        div_req;
    logic        div_signed;
    logic [31:0] div_x;
    logic [31:0] div_y;
    logic [31:0] div_s = 32'd0;
    logic [31:0] div_r = 32'd0;
    logic        div_complete = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        int          cyc;
        logic [31:0] x;
        logic [31:0] y;
        logic        sg;
    } req_t;

    typedef struct {
        int          cyc;
        logic [31:0] h;
        logic [31:0] l;
    } hilo_t;

    req_t  req_q[$];
    hilo_t hilo_q[$];
    logic  stall_q[$];

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic done = 1'b0;

    hilo_div_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .ex_div_valid (ex_div_valid),
        .ex_div_signed(ex_div_signed),
        .ex_src_a     (ex_src_a),
        .ex_src_b     (ex_src_b),
        .ex_hilo_use  (ex_hilo_use),
        .ex_mthi      (ex_mthi),
        .ex_mtlo      (ex_mtlo),
        .ex_wdata     (ex_wdata),
        .flush        (flush),
        .stall        (stall),
        .div_req      (div_req),
        .div_signed   (div_signed),
        .div_x        (div_x),
        .div_y        (div_y),
        .div_s        (div_s),
        .div_r        (div_r),
        .div_complete (div_complete),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    // Cycle counter: cycle k begins at the k-th rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Behavioural divider: samples the request at the falling edge, pulses
    // div_complete 33 cycles after the request cycle. Division by zero
    // returns all-ones quotient and the dividend as remainder.
    // ------------------------------------------------------------------
    initial begin : divider_model
        int          cnt;
        logic        busy;
        logic [31:0] q_v;
        logic [31:0] r_v;
        cnt  = 0;
        busy = 1'b0;
        q_v  = 32'd0;
        r_v  = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            div_complete = 1'b0;
            if (!resetn) begin
                busy = 1'b0;
            end else if (busy) begin
                cnt = cnt + 1;
                if (cnt == 33) begin
                    div_complete = 1'b1;
                    div_s        = q_v;
                    div_r        = r_v;
                    busy         = 1'b0;
                end
            end
            @(negedge clk);
            if (!resetn) begin
                busy = 1'b0;
            end else if (div_req && !busy) begin
                busy = 1'b1;
                cnt  = 0;
                if (div_y == 32'd0) begin
                    q_v = 32'hFFFF_FFFF;
                    r_v = div_x;
                end else if (div_signed) begin
                    q_v = $signed(div_x) / $signed(div_y);
                    r_v = $signed(div_x) % $signed(div_y);
                end else begin
                    q_v = div_x / div_y;
                    r_v = div_x % div_y;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks   = checks + 1;
        failures = failures + 1;
        $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endtask

    initial begin : monitor
        logic [31:0] ph;
        logic [31:0] pl;
        req_t        rq;
        hilo_t       hq;
        logic        es;
        #3;
        chk("reset_hi",         hi,                     32'd0);
        chk("reset_lo",         lo,                     32'd0);
        chk("reset_stall",      {31'd0, stall},         32'd0);
        chk("reset_div_req",    {31'd0, div_req},       32'd0);
        chk("reset_div_signed", {31'd0, div_signed},    32'd0);
        chk("reset_div_x",      div_x,                  32'd0);
        chk("reset_div_y",      div_y,                  32'd0);
        ph = 32'd0;
        pl = 32'd0;
        while (!done) begin
            @(negedge clk);
            if (stall_q.size() > 0) begin
                es = stall_q.pop_front();
                chk("stall", {31'd0, stall}, {31'd0, es});
            end
            if (div_req) begin
                if (req_q.size() == 0) begin
                    unexpected("div_req_unexpected");
                end else begin
                    rq = req_q.pop_front();
                    chk("req_cycle",  cyc,                 rq.cyc);
                    chk("div_x",      div_x,               rq.x);
                    chk("div_y",      div_y,               rq.y);
                    chk("div_signed", {31'd0, div_signed}, {31'd0, rq.sg});
                end
            end else begin
                chk("idle_div_x",      div_x,               32'd0);
                chk("idle_div_y",      div_y,               32'd0);
                chk("idle_div_signed", {31'd0, div_signed}, 32'd0);
            end
            if ((hi !== ph) || (lo !== pl)) begin
                if (hilo_q.size() == 0) begin
                    unexpected("hilo_change_unexpected");
                end else begin
                    hq = hilo_q.pop_front();
                    chk("hilo_cycle", cyc, hq.cyc);
                    chk("hi",         hi,  hq.h);
                    chk("lo",         lo,  hq.l);
                end
                ph = hi;
                pl = lo;
            end
        end
        chk("req_queue_drained",   req_q.size(),   32'd0);
        chk("hilo_queue_drained",  hilo_q.size(),  32'd0);
        chk("stall_queue_drained", stall_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: each drives one cycle and records expected stall.
    // ------------------------------------------------------------------
    task automatic cyc_drv(input logic v, input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic hu, input logic mh, input logic ml, input logic [31:0] wd,
                           input logic fl, input logic es);
        @(posedge clk);
        #1;
        ex_div_valid  = v;
        ex_div_signed = sg;
        ex_src_a      = a;
        ex_src_b      = b;
        ex_hilo_use   = hu;
        ex_mthi       = mh;
        ex_mtlo       = ml;
        ex_wdata      = wd;
        flush         = fl;
        stall_q.push_back(es);
    endtask

    task automatic drv_div(input logic sg, input logic [31:0] a, input logic [31:0] b, input logic es);
        cyc_drv(1'b1, sg, a, b, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, es);
    endtask

    task automatic drv_nop(input logic es);
        cyc_drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, es);
    endtask

    task automatic drv_mt(input logic mh, input logic ml, input logic [31:0] wd, input logic es);
        cyc_drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, mh, ml, wd, 1'b0, es);
    endtask

    task automatic drv_use(input logic es);
        cyc_drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, es);
    endtask

    task automatic drv_flush(input logic es);
        cyc_drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, es);
    endtask

    // Full division held in EX: stall cycles 0-34, request in cycle 1,
    // HI/LO visible in cycle 35 (the DONE cycle, stall low).
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el);
        int c0;
        drv_div(sg, a, b, 1'b1);
        c0 = cyc;
        req_q.push_back('{c0 + 1, a, b, sg});
        hilo_q.push_back('{c0 + 35, eh, el});
        for (int i = 1; i <= 34; i++) begin
            drv_div(sg, a, b, 1'b1);
        end
        drv_div(sg, a, b, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : stimulus
        int c0;
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        drv_nop(1'b0);
        drv_nop(1'b0);

        // DIVU 100/7 then back-to-back DIV -7/2.
        run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        drv_nop(1'b0);

        // Preset HI/LO through MTHI/MTLO.
        drv_mt(1'b1, 1'b0, 32'h1111_1111, 1'b0);
        hilo_q.push_back('{cyc + 1, 32'h1111_1111, 32'hFFFF_FFFD});
        drv_mt(1'b0, 1'b1, 32'h2222_2222, 1'b0);
        hilo_q.push_back('{cyc + 1, 32'h1111_1111, 32'h2222_2222});
        drv_nop(1'b0);

        // Flush in WAIT (cycle 10); MFHI from cycle 12 waits for the drain.
        drv_div(1'b0, 32'd40, 32'd3, 1'b1);
        c0 = cyc;
        req_q.push_back('{c0 + 1, 32'd40, 32'd3, 1'b0});
        for (int i = 1; i <= 9; i++) begin
            drv_div(1'b0, 32'd40, 32'd3, 1'b1);
        end
        drv_flush(1'b0);
        drv_nop(1'b0);
        for (int i = 12; i <= 34; i++) begin
            drv_use(1'b1);
        end
        drv_use(1'b0);
        drv_nop(1'b0);

        // Flush in ISSUE: no request; IDLE next cycle accepts MTHI.
        drv_div(1'b0, 32'd40, 32'd3, 1'b1);
        drv_flush(1'b0);
        drv_mt(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        hilo_q.push_back('{cyc + 1, 32'hDEAD_BEEF, 32'h2222_2222});
        drv_nop(1'b0);

        // MTLO arriving during WAIT: held, ignored in DONE, committed in IDLE.
        drv_div(1'b0, 32'd9, 32'd4, 1'b1);
        c0 = cyc;
        req_q.push_back('{c0 + 1, 32'd9, 32'd4, 1'b0});
        hilo_q.push_back('{c0 + 35, 32'd1, 32'd2});
        for (int i = 1; i <= 34; i++) begin
            drv_mt(1'b0, 1'b1, 32'hCAFE_F00D, 1'b1);
        end
        drv_mt(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
        drv_mt(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
        hilo_q.push_back('{cyc + 1, 32'd1, 32'hCAFE_F00D});
        drv_nop(1'b0);

        // Flush together with div_complete: result dropped, IDLE next cycle.
        drv_div(1'b0, 32'd50, 32'd5, 1'b1);
        c0 = cyc;
        req_q.push_back('{c0 + 1, 32'd50, 32'd5, 1'b0});
        for (int i = 1; i <= 33; i++) begin
            drv_div(1'b0, 32'd50, 32'd5, 1'b1);
        end
        drv_flush(1'b0);
        drv_mt(1'b1, 1'b0, 32'h1234_5678, 1'b0);
        hilo_q.push_back('{cyc + 1, 32'h1234_5678, 32'hCAFE_F00D});
        drv_nop(1'b0);

        // Division by zero.
`ifdef DIV_ZERO_SKIP_EN
        drv_div(1'b1, 32'd5, 32'd0, 1'b1);
        drv_div(1'b1, 32'd5, 32'd0, 1'b0);
        drv_nop(1'b0);
        drv_nop(1'b0);
`else
        run_div(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        drv_nop(1'b0);
`endif

        // Reset in cycle 20 of a division.
        drv_div(1'b0, 32'd100, 32'd3, 1'b1);
        c0 = cyc;
        req_q.push_back('{c0 + 1, 32'd100, 32'd3, 1'b0});
        for (int i = 1; i <= 19; i++) begin
            drv_div(1'b0, 32'd100, 32'd3, 1'b1);
        end
        drv_nop(1'b0);
        resetn = 1'b0;
        hilo_q.push_back('{cyc, 32'd0, 32'd0});
        drv_nop(1'b0);
        resetn = 1'b1;
        drv_mt(1'b1, 1'b0, 32'hAAAA_5555, 1'b0);
        hilo_q.push_back('{cyc + 1, 32'hAAAA_5555, 32'd0});
        for (int i = 0; i < 40; i++) begin
            drv_nop(1'b0);
        end

        @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule
